// File: rtl/athena_pkg.sv
// Shared definitions for the loop_inc index generator: state encoding and
// the default index width.
package athena_pkg;

    localparam int DATAWIDTH_DEF = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_FIN  = FIN
    } state_e;

endpackage

// File: rtl/inc_step.sv
// Combinational index + step adder. The extra sum bit carries out of the
// index width so the caller can detect overflow instead of wrapping.
module inc_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    // Widen both operands by one bit so the carry lands in sum[WIDTH]
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/loop_inc.sv
// loop_inc: emits Init, Init+step, ... up to an inclusive Limit on a
// valid/ready stream, then pulses Done for one cycle.
// Optional feature macro LOOP_INC_STRIDE_EN adds a Stride input that sets
// the step (a Stride of 0 is forced to 1 so the loop always ends).
//
// state | meaning
// IDLE  | waiting for Start; Init/Limit(/Stride) captured on Start
// RUN   | Idx offered with IdxValid=1, advances on each handshake
// FIN   | one-cycle Done pulse, Busy still high, then back to IDLE
module loop_inc
    import athena_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] Init,
    input  logic [DATAWIDTH-1:0] Limit,
`ifdef LOOP_INC_STRIDE_EN
    input  logic [DATAWIDTH-1:0] Stride,
`endif
    output logic [DATAWIDTH-1:0] Idx,
    output logic                 IdxValid,
    input  logic                 IdxReady,
    output logic                 Busy,
    output logic                 Done
);

    localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] idx_q, idx_d;
    logic [DATAWIDTH-1:0] limit_q, limit_d;
    logic [DATAWIDTH-1:0] step;
    logic [DATAWIDTH:0]   next_sum;
    logic                 next_past_end;

`ifdef LOOP_INC_STRIDE_EN
    logic [DATAWIDTH-1:0] stride_q, stride_d;

    // Stride is sanitised at capture time, so the stored value is the step
    always_comb begin
        step = stride_q;
    end
`else
    // Fixed unit step when the stride feature is compiled out
    always_comb begin
        step = ONE;
    end
`endif

    inc_step #(
        .WIDTH (DATAWIDTH)
    ) u_inc_step (
        .a   (idx_q),
        .b   (step),
        .sum (next_sum)
    );

    // Loop ends when the next index overshoots Limit or carries out
    always_comb begin
        next_past_end = next_sum[DATAWIDTH] || (next_sum[DATAWIDTH-1:0] > limit_q);
    end

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        limit_d = limit_q;
`ifdef LOOP_INC_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    limit_d = Limit;
`ifdef LOOP_INC_STRIDE_EN
                    stride_d = (Stride == '0) ? ONE : Stride;
`endif
                    if (Init <= Limit) begin
                        idx_d   = Init;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (IdxReady) begin
                    if (next_past_end) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d = next_sum[DATAWIDTH-1:0];
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            limit_q <= '0;
`ifdef LOOP_INC_STRIDE_EN
            stride_q <= ONE;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            limit_q <= limit_d;
`ifdef LOOP_INC_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    // Outputs decode directly from the state register
    always_comb begin
        Idx      = idx_q;
        IdxValid = (state_q == S_RUN);
        Busy     = (state_q == S_RUN) || (state_q == S_FIN);
        Done     = (state_q == S_FIN);
    end

endmodule

// File: tb/tb_loop_inc.sv
// Testbench for loop_inc. The reference model expands each loop into the
// full list of expected indices up front, then walks that list as the
// consumer accepts indices.
module tb_loop_inc;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic [7:0] Init;
    logic [7:0] Limit;
`ifdef LOOP_INC_STRIDE_EN
    logic [7:0] Stride;
`endif
    logic [7:0] Idx;
    logic       IdxValid;
    logic       IdxReady;
    logic       Busy;
    logic       Done;

    int n_tests = 0;
    int n_fail  = 0;

    loop_inc #(.DATAWIDTH(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Init     (Init),
        .Limit    (Limit),
`ifdef LOOP_INC_STRIDE_EN
        .Stride   (Stride),
`endif
        .Idx      (Idx),
        .IdxValid (IdxValid),
        .IdxReady (IdxReady),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // rmode: 0 = ready always high, 1 = random ready, 2 = ready 1,0,0,1,1 then 1
    task automatic run_loop(input int init, input int limit, input int stride, input int rmode);
        int exp_q[$];
        int step;
        int ptr;
        int cyc;
        bit r;
        bit pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        step = 1;
`ifdef LOOP_INC_STRIDE_EN
        step = (stride == 0) ? 1 : stride;
`endif
        for (int v = init; v <= limit; v += step) exp_q.push_back(v);

        @(negedge Clk);
        Start = 1'b1;
        Init  = init[7:0];
        Limit = limit[7:0];
`ifdef LOOP_INC_STRIDE_EN
        Stride = stride[7:0];
`endif
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Init  = 8'($urandom);
        Limit = 8'($urandom);
`ifdef LOOP_INC_STRIDE_EN
        Stride = 8'($urandom);
`endif
        ptr = 0;
        cyc = 0;
        forever begin
            @(negedge Clk);
            if (ptr < exp_q.size()) begin
                check_eq("idx_valid", 32'(IdxValid), 1);
                check_eq("idx", 32'(Idx), exp_q[ptr]);
                check_eq("done_in_run", 32'(Done), 0);
                check_eq("busy_in_run", 32'(Busy), 1);
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (cyc < 5) ? pat[cyc] : 1'b1;
                endcase
                IdxReady = r;
                Start    = 1'($urandom_range(0, 1));
                if (r) ptr++;
                cyc++;
                if (cyc > 4000) begin
                    check_eq("loop_timeout", cyc, 0);
                    break;
                end
            end else begin
                check_eq("done_pulse", 32'(Done), 1);
                check_eq("valid_in_fin", 32'(IdxValid), 0);
                check_eq("busy_in_fin", 32'(Busy), 1);
                Start    = 1'($urandom_range(0, 1));
                IdxReady = 1'($urandom_range(0, 1));
                @(negedge Clk);
                check_eq("done_cleared", 32'(Done), 0);
                check_eq("busy_idle", 32'(Busy), 0);
                check_eq("valid_idle", 32'(IdxValid), 0);
                Start = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        Rst      = 1'b1;
        Start    = 1'b0;
        Init     = '0;
        Limit    = '0;
        IdxReady = 1'b0;
`ifdef LOOP_INC_STRIDE_EN
        Stride   = '0;
`endif
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst_idx", 32'(Idx), 0);
        check_eq("rst_valid", 32'(IdxValid), 0);
        check_eq("rst_busy", 32'(Busy), 0);
        check_eq("rst_done", 32'(Done), 0);
        Rst = 1'b0;

        run_loop(3, 6, 1, 0);
        run_loop(10, 9, 1, 0);
        run_loop(254, 255, 1, 0);
        run_loop(0, 2, 1, 2);
        run_loop(0, 0, 1, 1);
        run_loop(255, 255, 1, 0);
        run_loop(0, 255, 1, 0);

        // Abort mid-loop; Start asserted alongside Rst must lose
        @(negedge Clk);
        Start = 1'b1;
        Init  = 8'd0;
        Limit = 8'd9;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        IdxReady = 1'b1;
        repeat (6) @(negedge Clk);
        check_eq("pre_rst_idx", 32'(Idx), 5);
        Rst   = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        check_eq("abort_idx", 32'(Idx), 0);
        check_eq("abort_valid", 32'(IdxValid), 0);
        check_eq("abort_busy", 32'(Busy), 0);
        check_eq("abort_done", 32'(Done), 0);
        Rst   = 1'b0;
        Start = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            check_eq("post_abort_done", 32'(Done), 0);
            check_eq("post_abort_busy", 32'(Busy), 0);
        end
        run_loop(2, 4, 1, 0);

`ifdef LOOP_INC_STRIDE_EN
        run_loop(1, 10, 3, 0);
        run_loop(1, 4, 0, 0);
        run_loop(250, 255, 4, 0);
        run_loop(0, 255, 200, 1);
`endif

        for (int i = 0; i < 30; i++) begin
            int a;
            int b;
            int s;
            a = $urandom_range(0, 255);
            b = (a + $urandom_range(0, 24)) % 256;
            s = $urandom_range(0, 5);
            run_loop(a, b, s, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/loop_inc.md
# loop_inc

Sequential loop-index generator: the counting-up counterpart of the datapath decrement component. It is loaded once with an initial value and an inclusive limit, then emits the indices Init, Init+1, …, Limit on a valid/ready stream, one index per accepted handshake. When the last index has been accepted, it pulses Done. Scheduled datapaths use it wherever a loop counter currently needs a separate register, an incrementer and a comparator.

## Interface
- DATAWIDTH, 8, width of the index, the initial value and the limit (unsigned).
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle request to begin a loop; sampled only in IDLE.
- Init  input  DATAWIDTH  first index; captured when Start is accepted.
- Limit  input  DATAWIDTH  last index, inclusive; captured when Start is accepted.
- Idx  output  DATAWIDTH  current index; valid while IdxValid=1.
- IdxValid  output  1  Idx is offered to the consumer.
- IdxReady  input  1  consumer accepts Idx this cycle.
- Busy  output  1  high in the RUN and FIN states.
- Done  output  1  one-cycle pulse marking the end of the loop.

## Operation
- States are IDLE, RUN and FIN.
- **IDLE**
  - Start=1 captures Init and Limit.
  - If Init ≤ Limit (unsigned): go to RUN with Idx=Init.
  - Otherwise (empty range): go directly to FIN.
- **RUN**
  - IdxValid=1 throughout; Idx holds steady until the handshake IdxValid & IdxReady.
  - On a handshake, compute next = Idx + step in DATAWIDTH+1 bits (step=1 unless configured otherwise).
  - If next > Limit, or next carries out of DATAWIDTH bits: go to FIN.
  - Otherwise: Idx ← next[DATAWIDTH-1:0] and stay in RUN.
- **FIN**
  - Done=1 and IdxValid=0 for exactly one cycle, then go to IDLE.
- Start is ignored in RUN and FIN; there is no queuing of requests.
- Limit = 2^DATAWIDTH−1 is legal. The carry-out ends the loop, so the index never wraps to 0.
- Captured Init and Limit are unaffected by changes on those inputs after Start has been accepted.
- Reset values:
  - state=IDLE
  - Idx=0, IdxValid=0, Busy=0, Done=0
  - internal limit register = 0
- Rst asserted in any state, including mid-loop, forces these values on the next edge. No Done pulse is produced for an aborted loop.
- Rst has priority over Start in the same cycle.

## Timing
- Start accepted on edge 0 → IdxValid=1 with Idx=Init from cycle 1.
- Throughput is one index per cycle while IdxReady=1.
- Last handshake on edge k → Done=1 and Busy=1 in cycle k+1; Busy=0 in cycle k+2.
- Empty range: Start on edge 0 → Done=1 in cycle 1, IDLE in cycle 2. No IdxValid is ever raised.
- Earliest new Start is in the first IDLE cycle after FIN, giving back-to-back loops with a 2-cycle gap.
- IdxReady low stalls indefinitely with no loss and no change of Idx.
- Done never coincides with IdxValid.

## Configuration
- Macro: LOOP_INC_STRIDE_EN.
- **Defined**
  - Adds input Stride (DATAWIDTH bits), captured alongside Init and Limit when Start is accepted.
  - step = captured Stride.
  - A Stride of 0 is treated as 1 to guarantee termination.
  - Termination uses the same rule: next > Limit or carry-out. For example, Init=250, Limit=255, Stride=4 emits 250 and 254, then finishes.
- **Undefined**
  - The Stride port is absent and step is the constant 1.
  - Behaviour is otherwise identical.

## Structure
- A shared package (athena_pkg) holds:
  - the state encoding localparams: IDLE=2'd0, RUN=2'd1, FIN=2'd2;
  - the default DATAWIDTH.
- Natural sub-module: inc_step. It is a combinational DATAWIDTH-bit adder producing a DATAWIDTH+1-bit sum (index + step) with carry-out, instantiated once in the RUN next-state path.
- The FSM, the Idx register and the limit/stride capture registers all live in the top module.

## Test plan
- DATAWIDTH=8, Init=3, Limit=6, IdxReady held 1 → Idx 3,4,5,6 in cycles 1–4, Done in cycle 5, Busy=0 in cycle 6.
- Init=10, Limit=9 → Done in cycle 1, IdxValid never asserted.
- Init=254, Limit=255 → Idx 254, 255, then Done; Idx never shows 0.
- Init=0, Limit=2, IdxReady toggled 1,0,0,1,1 → Idx 0, held 1 for 3 cycles, then 2, then Done; no index skipped or repeated.
- Rst asserted while Idx=5 in a loop 0..9 → next cycle Idx=0, IdxValid=0, Busy=0, no Done; Start 2 cycles later restarts cleanly.
- With LOOP_INC_STRIDE_EN, Init=1, Limit=10, Stride=3 → Idx 1,4,7,10, then Done. Stride=0 → step of 1.
